// File: rtl/shake_pkg.sv
// Shared SHAKE core types and constants.
// Lane width, rate sizes in words, output FSM states, rate helper.
package shake_pkg;

  localparam int SHAKE_DATA_W        = 64;
  localparam int SHAKE128_RATE_WORDS = 21;
  localparam int SHAKE256_RATE_WORDS = 17;
  localparam int SHAKE_CNT_W         = 5;

  typedef enum logic {
    EMPTY,
    DRAIN
  } out_state_t;

  function automatic logic [SHAKE_CNT_W-1:0] rate_words(
    input logic rate_sel
  );
    if (rate_sel)
      return SHAKE_CNT_W'(SHAKE256_RATE_WORDS);
    return SHAKE_CNT_W'(SHAKE128_RATE_WORDS);
  endfunction

endpackage

// File: rtl/shake_output_stage_block_shift_reg.sv
// Rate-block shift register: parallel load, shift right one lane.
// Ports: clk, rst, load_i, shift_i, din_i (block), word_o (lane 0).
module block_shift_reg #(
  parameter int DATA_W = 64,
  parameter int WORDS  = 21
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_i,
  input  logic                    shift_i,
  input  logic [DATA_W*WORDS-1:0] din_i,
  output logic [DATA_W-1:0]       word_o
);

  logic [DATA_W*WORDS-1:0] data_q;

  always_ff @(posedge clk) begin
    if (rst)
      data_q <= '0;
    else if (load_i)
      data_q <= din_i;
    else if (shift_i)
      data_q <= data_q >> DATA_W;
  end

  assign word_o = data_q[DATA_W-1:0];

endmodule

// File: rtl/shake_output_stage.sv
// SHAKE output stage: buffers one squeezed block, drains 64-bit words.
// Ports: block write side, available flag, dout stream, err_overwrite.
module shake_output_stage
  import shake_pkg::*;
#(
  parameter int DATA_W    = SHAKE_DATA_W,
  parameter int MAX_WORDS = SHAKE128_RATE_WORDS,
  parameter int CNT_W     = SHAKE_CNT_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_W*MAX_WORDS-1:0] block_in,
  input  logic                        rate_sel,
  input  logic                        output_buffer_we,
  input  logic                        last_output_block_wr,
  input  logic [CNT_W-1:0]            last_block_words,
  output logic                        output_buffer_available,
  input  logic                        output_buffer_available_clr,
  output logic [DATA_W-1:0]           dout,
  output logic                        dout_valid,
  input  logic                        dout_ready,
  output logic                        dout_last,
  output logic                        err_overwrite
);

  out_state_t       state_q, state_d;
  logic [CNT_W-1:0] words_q, words_d;
  logic             last_q, last_d;
  logic             avail_q, avail_d;
  logic             err_q, err_d;
  logic             load;
  logic             shift;
  logic [CNT_W-1:0] rw;

  block_shift_reg #(
    .DATA_W (DATA_W),
    .WORDS  (MAX_WORDS)
  ) u_sreg (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .shift_i (shift),
    .din_i   (block_in),
    .word_o  (dout)
  );

  assign rw = CNT_W'(rate_words(rate_sel));

  always_comb begin
    state_d = state_q;
    words_d = words_q;
    last_d  = last_q;
    avail_d = avail_q;
    err_d   = err_q;
    load    = 1'b0;
    shift   = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (output_buffer_we) begin
          load    = 1'b1;
          words_d = rw;
          // zero means a full final block; oversize is clamped
          if (last_output_block_wr &&
              last_block_words != '0)
            words_d = (last_block_words > rw) ?
                      rw : last_block_words;
          last_d  = last_output_block_wr;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (output_buffer_we)
          err_d = 1'b1;
        if (dout_ready) begin
          shift   = 1'b1;
          words_d = words_q - CNT_W'(1);
          if (words_q == CNT_W'(1)) begin
            state_d = EMPTY;
            avail_d = 1'b1;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
    // clear has priority over the final-word set
    if (output_buffer_available_clr)
      avail_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      words_q <= '0;
      last_q  <= 1'b0;
      avail_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      words_q <= words_d;
      last_q  <= last_d;
      avail_q <= avail_d;
      err_q   <= err_d;
    end
  end

  assign dout_valid = (state_q == DRAIN);
  assign dout_last  = dout_valid & last_q &
                      (words_q == CNT_W'(1));
  assign output_buffer_available = avail_q;
  assign err_overwrite = err_q;

endmodule

// File: doc/shake_output_stage.md
Name: shake_output_stage

Overview:
- Third pipeline stage of the SHAKE core, after the permutation stage.
- Owns the output buffer that the permutation FSM writes squeezed rate blocks into. Drains each block as 64-bit words on a valid/ready stream toward the Dilithium datapath.
- Owns the output_buffer_available flag and returns it to the permutation stage. This is the reader/consumer end of the permute-to-output handshake.

Parameters:
- DATA_W, 64, width of one output word (one Keccak lane).
- MAX_WORDS, 21, buffer depth in words (SHAKE128 rate = 1344 bits).
- CNT_W, 5, width of word counters; must satisfy 2**CNT_W > MAX_WORDS.

Ports:
- clk  in  1  Clock.
- rst  in  1  Reset; synchronous, active-high.
- block_in  in  DATA_W*MAX_WORDS  Rate portion of the Keccak state; lane 0 in bits [63:0].
- rate_sel  in  1  0 = SHAKE128 (21 words), 1 = SHAKE256 (17 words); sampled on output_buffer_we.
- output_buffer_we  in  1  Permutation stage writes block_in into the buffer.
- last_output_block_wr  in  1  Block being written is the final one of the digest; sampled on we.
- last_block_words  in  CNT_W  Valid words in the final block, 1..block size; 0 means full block; sampled on we when last_output_block_wr=1.
- output_buffer_available  out  1  Buffer empty and writable.
- output_buffer_available_clr  in  1  Clears the available flag; driven by the permutation stage (we OR rst).
- dout  out  DATA_W  Output word.
- dout_valid  out  1  dout holds a valid word.
- dout_ready  in  1  Downstream accepts the word.
- dout_last  out  1  Final word of the digest; qualified by dout_valid.
- err_overwrite  out  1  Sticky flag: a write arrived while the buffer was not empty.

Behaviour:
- Reset values: output_buffer_available=1, dout_valid=0, dout_last=0, dout=0, err_overwrite=0, state EMPTY, all counters 0.
- A reset in any state discards buffered data and any word in flight.
- States:
  - EMPTY: buffer empty, available=1.
  - DRAIN: words remain to be sent.
- Write acceptance: in EMPTY, output_buffer_we at edge N does the following:
  - Captures block_in into the shift register.
  - Loads words_left with 21 or 17 (per rate_sel), or with last_block_words if last_output_block_wr=1 and last_block_words != 0.
  - Latches the last flag.
  - Moves to DRAIN.
- Write-to-output latency: dout_valid=1 in cycle N+1, with dout = block_in[63:0].
- Available flag:
  - Cleared on output_buffer_available_clr.
  - Set on the handshake (dout_valid & dout_ready) of the final word of a block.
  - If clear and set coincide, clear wins; the permutation stage must never do this.
- Drain:
  - Each handshake shifts the register right by DATA_W and decrements words_left.
  - When words_left is 1 at a handshake, the next state is EMPTY and dout_valid drops in the following cycle.
  - No bubbles between words while dout_ready stays high: one word per cycle.
- Stream rules:
  - dout and dout_last stay stable while dout_valid=1 and dout_ready=0.
  - dout_valid never drops without a handshake, except on rst.
- dout_last:
  - Equals latched_last & (words_left == 1), asserted only alongside dout_valid.
  - Not asserted for intermediate squeeze blocks.
- Back-to-back blocks: after the final-word handshake at edge M, available=1 from cycle M+1. A we in cycle M+1 produces valid data in cycle M+2, giving a one-cycle gap.
- Overwrite: output_buffer_we in DRAIN is ignored (buffer contents untouched) and sets err_overwrite. Only rst clears err_overwrite.
- Width rules:
  - Block size 21 for SHAKE128 and 17 for SHAKE256.
  - last_block_words greater than the block size is clamped to the block size.
  - Unused upper lanes (words 17..20 for SHAKE256) are never output.

Decomposition:
- Shared package shake_pkg holds:
  - SHAKE_DATA_W=64, SHAKE128_RATE_WORDS=21, SHAKE256_RATE_WORDS=17.
  - The enum out_state_t {EMPTY, DRAIN}.
  - A function rate_words(rate_sel).
- One natural sub-module, block_shift_reg: parallel load, shift by DATA_W on enable, presents word 0. The FSM, counters and available flag stay in shake_output_stage.

Test Plan:
- SHAKE128 single last block, last_block_words=4, block lanes 0x0..0x14, dout_ready=1: dout = 0x0,0x1,0x2,0x3 on cycles N+1..N+4; dout_last only with 0x3; available=1 in cycle N+5.
- SHAKE256 intermediate block, last flag=0, dout_ready=1: exactly 17 words, lanes 0..16; dout_last never asserted; lanes 17..20 never seen.
- Backpressure: dout_ready toggling 1,0,0,1,… over 21 words: every word appears exactly once, in order; dout held stable during stalls; available rises only after the 21st handshake.
- Two back-to-back blocks, permutation model writing as soon as available=1: second block's first word appears 2 cycles after the first block's last handshake; no data loss.
- output_buffer_we asserted after 5 of 21 words drained: err_overwrite=1; remaining 16 words come from the original block.
- rst asserted mid-DRAIN after 3 words: next cycle dout_valid=0, available=1, err_overwrite=0; a new write then drains from lane 0.
